// File: rtl/mul_acc.sv
`default_nettype none
// ============================================================================
// Module   : mul_acc
// Brief    : Pipelined signed multiply-accumulate stage. A registered
//            product stage feeds a saturating accumulator. The sum of each
//            period, together with a sticky overflow flag, is handed to the
//            consumer through a valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
module mul_acc #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_ACC = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic [WIDTH_IN-1:0]  a_i,
  input  logic [WIDTH_IN-1:0]  b_i,
  input  logic                 last_i,
  output logic                 in_ready_o,
  output logic [WIDTH_ACC-1:0] acc_o,
  output logic                 ovf_o,
  output logic                 acc_valid_o,
  input  logic                 acc_ready_i
);

  // Full-precision product width, and the accumulator width plus one guard
  // bit. The guard bit lets overflow be seen before the clamp.
  localparam int c_PROD_W = 2 * WIDTH_IN;
  localparam int c_SUM_W  = WIDTH_ACC + 1;
  localparam int c_EXT_W  = c_SUM_W - c_PROD_W;

  // Saturation limits of a WIDTH_ACC-bit two's complement value.
  localparam logic [WIDTH_ACC-1:0] c_ACC_MAX = {1'b0, {(WIDTH_ACC-1){1'b1}}};
  localparam logic [WIDTH_ACC-1:0] c_ACC_MIN = {1'b1, {(WIDTH_ACC-1){1'b0}}};

  // An accumulator narrower than the product would silently lose the
  // product's sign and magnitude, so refuse to build it.
  generate
    if (WIDTH_ACC < 2 * WIDTH_IN) begin : g_width_check
      $error("mul_acc: WIDTH_ACC must be at least 2*WIDTH_IN");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // Stage 1: product register.
  logic [c_PROD_W-1:0]  r_p;
  logic                 r_p_last;
  logic                 r_p_valid;

  // Stage 2: running accumulator of the current period.
  logic [WIDTH_ACC-1:0] r_acc;
  logic                 r_ovf_acc;

  // Output register towards the consumer.
  logic [WIDTH_ACC-1:0] r_acc_out;
  logic                 r_ovf_out;
  logic                 r_acc_valid;

  // --------------------------------------------------------------------------
  // Combinational datapath and handshake
  // --------------------------------------------------------------------------
  logic signed [c_PROD_W-1:0] w_prod;
  logic [c_SUM_W-1:0]         w_acc_ext;
  logic [c_SUM_W-1:0]         w_p_ext;
  logic [c_SUM_W-1:0]         w_sum;
  logic                       w_clamp;
  logic [WIDTH_ACC-1:0]       w_sat;
  logic                       w_ovf_next;
  logic                       w_stall;
  logic                       w_accept;
  logic                       w_advance;
  logic                       w_load;
  logic                       w_drain;

  // Only a closing product needs the output register. It stalls the whole
  // pipe when the register still holds a result the consumer has not taken.
  // Products in the middle of a period never touch the output, so they
  // always flow.
  assign w_stall   = r_acc_valid && !acc_ready_i && r_p_valid && r_p_last;
  assign w_accept  = en_i && !w_stall;
  assign w_advance = r_p_valid && !w_stall;
  assign w_load    = w_advance && r_p_last;
  assign w_drain   = r_acc_valid && acc_ready_i;

  // Signed multiply at full 2*WIDTH_IN precision; it cannot overflow.
  assign w_prod = $signed(a_i) * $signed(b_i);

  // Both addends are sign-extended to one bit wider than the accumulator.
  // The wider sum is then exact.
  assign w_acc_ext = {r_acc[WIDTH_ACC-1], r_acc};
  assign w_p_ext   = {{c_EXT_W{r_p[c_PROD_W-1]}}, r_p};
  assign w_sum     = w_acc_ext + w_p_ext;

  // The sum leaves the representable range exactly when the guard bit and
  // the accumulator sign bit disagree. The guard bit then gives the true
  // sign, and so tells which limit to clamp to.
  assign w_clamp    = w_sum[c_SUM_W-1] ^ w_sum[WIDTH_ACC-1];
  assign w_sat      = w_clamp ? (w_sum[c_SUM_W-1] ? c_ACC_MIN : c_ACC_MAX)
                              : w_sum[WIDTH_ACC-1:0];
  assign w_ovf_next = r_ovf_acc | w_clamp;

  assign in_ready_o  = !w_stall;
  assign acc_o       = r_acc_out;
  assign ovf_o       = r_ovf_out;
  assign acc_valid_o = r_acc_valid;

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------
  // Stage 1: capture the product of each accepted operand pair. Hold while
  // stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p       <= '0;
      r_p_last  <= 1'b0;
      r_p_valid <= 1'b0;
    end else if (!w_stall) begin
      r_p_valid <= w_accept;
      if (w_accept) begin
        r_p      <= w_prod;
        r_p_last <= last_i;
      end
    end
  end

  // Stage 2: fold the product into the running sum. The closing product
  // restarts the period from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_ovf_acc <= 1'b0;
    end else if (w_advance) begin
      if (r_p_last) begin
        r_acc     <= '0;
        r_ovf_acc <= 1'b0;
      end else begin
        r_acc     <= w_sat;
        r_ovf_acc <= w_ovf_next;
      end
    end
  end

  // Output register. A new result may replace one being drained on the same
  // edge, so back-to-back periods flow without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_out   <= '0;
      r_ovf_out   <= 1'b0;
      r_acc_valid <= 1'b0;
    end else if (w_load) begin
      r_acc_out   <= w_sat;
      r_ovf_out   <= w_ovf_next;
      r_acc_valid <= 1'b1;
    end else if (w_drain) begin
      r_acc_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_acc
// Brief    : Self-checking bench for mul_acc. Two instances (24-bit and
//            16-bit accumulators) share one stimulus stream. Each instance
//            has its own arithmetic reference model and result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        last;
  logic        acc_ready;
  logic [7:0]  a;
  logic [7:0]  b;

  logic        in_ready24, ovf24, valid24;
  logic [23:0] acc24;
  logic        in_ready16, ovf16, valid16;
  logic [15:0] acc16;

  always #5 clk = ~clk;

  mul_acc #(.WIDTH_IN(8), .WIDTH_ACC(24)) u_dut24 (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
    .a_i         (a),
    .b_i         (b),
    .last_i      (last),
    .in_ready_o  (in_ready24),
    .acc_o       (acc24),
    .ovf_o       (ovf24),
    .acc_valid_o (valid24),
    .acc_ready_i (acc_ready)
  );

  mul_acc #(.WIDTH_IN(8), .WIDTH_ACC(16)) u_dut16 (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
    .a_i         (a),
    .b_i         (b),
    .last_i      (last),
    .in_ready_o  (in_ready16),
    .acc_o       (acc16),
    .ovf_o       (ovf16),
    .acc_valid_o (valid16),
    .acc_ready_i (acc_ready)
  );

  typedef struct {
    longint val;
    bit     ovf;
  } res_t;

  int     tests = 0;
  int     fails = 0;
  res_t   q24[$];
  res_t   q16[$];
  longint s24, s16;
  bit     o24, o16;
  bit     accepted;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference rule: add the product, then clamp to the signed w-bit range.
  // Any clamp sets the period's sticky overflow flag.
  function automatic void acc_step(inout longint s, inout bit o,
                                   input longint p, input int w);
    longint mx, mn;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -(longint'(1) <<< (w - 1));
    s = s + p;
    if (s > mx) begin
      s = mx;
      o = 1'b1;
    end else if (s < mn) begin
      s = mn;
      o = 1'b1;
    end
  endfunction

  // Runs before each rising edge, while inputs and outputs are stable.
  // It models what that edge does. It checks every consumed result against
  // the scoreboard, then records any accepted operand.
  task automatic monitor();
    res_t   e;
    longint p;
    accepted = 1'b0;
    if (rst) begin
      q24.delete();
      q16.delete();
      s24 = 0; s16 = 0; o24 = 1'b0; o16 = 1'b0;
      return;
    end
    if (valid24 && acc_ready) begin
      check("result24_expected", q24.size() > 0, 1);
      if (q24.size() > 0) begin
        e = q24.pop_front();
        check("acc24", $signed(acc24), e.val);
        check("ovf24", ovf24, e.ovf);
      end
    end
    if (valid16 && acc_ready) begin
      check("result16_expected", q16.size() > 0, 1);
      if (q16.size() > 0) begin
        e = q16.pop_front();
        check("acc16", $signed(acc16), e.val);
        check("ovf16", ovf16, e.ovf);
      end
    end
    p = longint'($signed(a)) * longint'($signed(b));
    if (en && in_ready24) begin
      accepted = 1'b1;
      acc_step(s24, o24, p, 24);
      if (last) begin
        q24.push_back('{val: s24, ovf: o24});
        s24 = 0; o24 = 1'b0;
      end
    end
    if (en && in_ready16) begin
      acc_step(s16, o16, p, 16);
      if (last) begin
        q16.push_back('{val: s16, ovf: o16});
        s16 = 0; o16 = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Present one operand and hold it until it is accepted (bounded wait).
  task automatic send(input int av, input int bv, input bit l);
    en = 1'b1; a = av[7:0]; b = bv[7:0]; last = l;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (accepted) break;
    end
    check("send_accepted", accepted, 1);
    en = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_acc24"},   acc24, 0);
    check({tag, "_ovf24"},   ovf24, 0);
    check({tag, "_valid24"}, valid24, 0);
    check({tag, "_rdy24"},   in_ready24, 1);
    check({tag, "_acc16"},   acc16, 0);
    check({tag, "_ovf16"},   ovf16, 0);
    check({tag, "_valid16"}, valid16, 0);
    check({tag, "_rdy16"},   in_ready16, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; last = 1'b0; acc_ready = 1'b1; a = '0; b = '0;
    s24 = 0; s16 = 0; o24 = 1'b0; o16 = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check_idle_outputs("reset");

    // Basic period: 12 - 10 + 49 = 51, valid for exactly one cycle.
    send(3, 4, 0);
    send(-2, 5, 0);
    send(7, 7, 1);
    check("basic_not_yet_valid", valid24, 0);
    tick();
    check("basic_valid", valid24, 1);
    check("basic_acc", $signed(acc24), 51);
    check("basic_ovf", ovf24, 0);
    tick();
    check("basic_one_cycle", valid24, 0);

    // Back-to-back periods of length 1.
    send(1, 1, 1);
    send(2, 2, 1);
    check("b2b_first", $signed(acc24), 1);
    send(-3, 3, 1);
    check("b2b_second", $signed(acc24), 4);
    check("b2b_second_valid", valid24, 1);
    tick();
    check("b2b_third", $signed(acc24), -9);
    tick();
    check("b2b_drained", valid24, 0);

    // Saturation: 16384 + 16384 exceeds the 16-bit range.
    send(-128, -128, 0);
    send(-128, -128, 1);
    tick();
    check("sat_pos_acc16", $signed(acc16), 32767);
    check("sat_pos_ovf16", ovf16, 1);
    check("sat_pos_acc24", $signed(acc24), 32768);
    check("sat_pos_ovf24", ovf24, 0);
    send(1, 1, 1);
    tick();
    check("sat_after_acc16", $signed(acc16), 1);
    check("sat_after_ovf16", ovf16, 0);
    send(-128, 127, 0);
    send(-128, 127, 0);
    send(-128, 127, 1);
    tick();
    check("sat_neg_acc16", $signed(acc16), -32768);
    check("sat_neg_ovf16", ovf16, 1);
    check("sat_neg_acc24", $signed(acc24), -48768);
    tick();

    // Backpressure: 12 is held while the closing product 6 waits.
    acc_ready = 1'b0;
    send(3, 4, 1);
    send(2, 3, 1);
    check("bp_in_ready", in_ready24, 0);
    check("bp_held_acc", $signed(acc24), 12);
    check("bp_held_valid", valid24, 1);
    en = 1'b1; a = 8'd1; b = 8'd1; last = 1'b1;
    repeat (3) begin
      tick();
      check("bp_stable_acc", $signed(acc24), 12);
      check("bp_stable_ready", in_ready24, 0);
    end
    acc_ready = 1'b1;
    tick();
    check("bp_next_acc", $signed(acc24), 6);
    check("bp_next_valid", valid24, 1);
    en = 1'b0;
    tick();
    check("bp_held_op_acc", $signed(acc24), 1);
    tick();
    check("bp_drained", valid24, 0);

    // Reset mid-period discards the partial sum.
    send(5, 5, 0);
    send(5, 5, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("midreset");
    send(1, 2, 1);
    tick();
    check("midreset_acc", $signed(acc24), 2);
    tick();

    // en gating: last_i without en_i neither closes nor disturbs the period.
    send(2, 2, 0);
    en = 1'b0; last = 1'b1; a = 8'd9; b = 8'd9;
    repeat (3) begin
      tick();
      check("gate_no_valid", valid24, 0);
    end
    send(1, 1, 1);
    tick();
    check("gate_acc", $signed(acc24), 5);
    tick();

    // Randomized traffic with backpressure and occasional reset.
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(3) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      last      = ($urandom_range(3) == 0);
      acc_ready = ($urandom_range(3) != 0);
      rst       = ($urandom_range(63) == 0);
      tick();
    end
    rst = 1'b0; en = 1'b0; acc_ready = 1'b1;
    repeat (5) tick();
    check("final_q24_empty", q24.size(), 0);
    check("final_q16_empty", q16.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
